cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 8 +
 rtl/cdb_src_fifo.sv | 45 ++++
 rtl/cdb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared tag/value widths and the round-robin scan helper
package cdb_arbiter_pkg;
    localparam int ROB_ID_WIDTH = 4;
    localparam int VAL_WIDTH    = 32;
    function automatic int scan_pos(input int src, input int ptr, input int n);
        return (src + n - ptr) % n;
    endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source result queue feeding the CDB arbiter
module cdb_src_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = 4,
    parameter int VW    = 32
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [LW-1:0] lab_i,
    input  logic [VW-1:0] val_i,
    output logic [LW-1:0] lab_o,
    output logic [VW-1:0] val_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          empty_next_o
);
    localparam int PW = $clog2(DEPTH);
    logic [LW+VW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    always_comb begin
        wr_d  = clr_i ? '0 : wr_q + PW'(push_i);
        rd_d  = clr_i ? '0 : rd_q + PW'(pop_i);
        cnt_d = clr_i ? '0 : cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
    assign full_o         = cnt_q == (PW+1)'(DEPTH);
    assign empty_o        = cnt_q == '0;
    assign empty_next_o   = cnt_d == '0;
    assign {lab_o, val_o} = mem_q[rd_q];
    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= {lab_i, val_i};
    always_ff @(posedge clk or negedge rst_in)
        if (!rst_in) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: queues results per producer and broadcasts up to NUM_BUS of them
// per cycle on the common data bus, round-robin across producers.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int NUM_BUS    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_ID_W   = ROB_ID_WIDTH,
    parameter int VAL_W      = VAL_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*ROB_ID_W-1:0] src_lab,
    input  logic [NUM_SRC*VAL_W-1:0]    src_val,
    output logic [NUM_BUS-1:0]          bus_en,
    output logic [NUM_BUS*ROB_ID_W-1:0] bus_lab,
    output logic [NUM_BUS*VAL_W-1:0]    bus_val,
    output logic                        pending
);
    localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC-1:0]          full, empty, empty_next, grant, push, pop;
    logic [ROB_ID_W-1:0]         head_lab [NUM_SRC];
    logic [VAL_W-1:0]            head_val [NUM_SRC];
    logic [SW-1:0]               rr_q, rr_d;
    logic [NUM_BUS-1:0]          en_q, en_d;
    logic [NUM_BUS*ROB_ID_W-1:0] lab_q, lab_d;
    logic [NUM_BUS*VAL_W-1:0]    val_q, val_d;
    logic                        pend_q, live;
    assign live      = rdy_in & ~flush;
    assign src_ready = ~full;
    assign push      = src_valid & ~full & {NUM_SRC{live}};
    assign pop       = grant & {NUM_SRC{live}};
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .LW(ROB_ID_W), .VW(VAL_W)) u_fifo (
            .clk          (clk),
            .rst_in       (rst_in),
            .clr_i        (rdy_in & flush),
            .push_i       (push[i]),
            .pop_i        (pop[i]),
            .lab_i        (src_lab[i*ROB_ID_W +: ROB_ID_W]),
            .val_i        (src_val[i*VAL_W +: VAL_W]),
            .lab_o        (head_lab[i]),
            .val_o        (head_val[i]),
            .full_o       (full[i]),
            .empty_o      (empty[i]),
            .empty_next_o (empty_next[i])
        );
    end
    // A source's lane is the number of non-empty sources ahead of it in scan order.
    always_comb begin : arb
        int pos  [NUM_SRC];
        int rank [NUM_SRC];
        int last, last_pos;
        for (int s = 0; s < NUM_SRC; s++) pos[s] = scan_pos(s, int'(rr_q), NUM_SRC);
        for (int s = 0; s < NUM_SRC; s++) begin
            rank[s] = 0;
            for (int t = 0; t < NUM_SRC; t++) rank[s] += (!empty[t] && pos[t] < pos[s]) ? 1 : 0;
            grant[s] = !empty[s] && rank[s] < NUM_BUS;
        end
        last     = 0;
        last_pos = -1;
        for (int s = 0; s < NUM_SRC; s++)
            if (grant[s] && pos[s] > last_pos) begin
                last     = s;
                last_pos = pos[s];
            end
        rr_d  = |grant ? SW'((last + 1) % NUM_SRC) : rr_q;
        en_d  = '0;
        lab_d = lab_q;
        val_d = val_q;
        for (int l = 0; l < NUM_BUS; l++)
            for (int s = 0; s < NUM_SRC; s++)
                if (grant[s] && rank[s] == l) begin
                    en_d[l]                          = 1'b1;
                    lab_d[l*ROB_ID_W +: ROB_ID_W] = head_lab[s];
                    val_d[l*VAL_W +: VAL_W]       = head_val[s];
                end
    end
    always_ff @(posedge clk or negedge rst_in)
        if (!rst_in) begin
            rr_q   <= '0;
            en_q   <= '0;
            lab_q  <= '0;
            val_q  <= '0;
            pend_q <= 1'b0;
        end else if (rdy_in) begin
            rr_q   <= flush ? '0 : rr_d;
            en_q   <= flush ? '0 : en_d;
            lab_q  <= flush ? lab_q : lab_d;
            val_q  <= flush ? val_q : val_d;
            pend_q <= ~&empty_next;
        end
    assign bus_en  = en_q;
    assign bus_lab = lab_q;
    assign bus_val = val_q;
    assign pending = pend_q;
endmodule
